// File: rtl/ctrl_pipe_pkg.sv
// Shared types for the RV32I(M) decode/control pipeline.
// Holds the opcode/funct3 encodings, datapath mux selects, the multiply/divide
// kind tag and the packed control word carried down the post-ID stages.
package ctrl_pipe_pkg;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011
   } rv32i_opcode_t;

   typedef enum logic [2:0] {
      beq  = 3'b000,
      bne  = 3'b001,
      blt  = 3'b100,
      bge  = 3'b101,
      bltu = 3'b110,
      bgeu = 3'b111
   } branch_funct3_t;

   typedef enum logic [2:0] {
      lb  = 3'b000,
      lh  = 3'b001,
      lw  = 3'b010,
      lbu = 3'b100,
      lhu = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      add_f3  = 3'b000,
      sll_f3  = 3'b001,
      slt_f3  = 3'b010,
      sltu_f3 = 3'b011,
      axor_f3 = 3'b100,
      sr_f3   = 3'b101,
      aor_f3  = 3'b110,
      aand_f3 = 3'b111
   } arith_funct3_t;

   typedef enum logic [2:0] {
      mul    = 3'b000,
      mulh   = 3'b001,
      mulhsu = 3'b010,
      mulhu  = 3'b011,
      div    = 3'b100,
      divu   = 3'b101,
      rem    = 3'b110,
      remu   = 3'b111
   } m_funct3_t;

   typedef enum logic [2:0] {
      alu_add = 3'b000,
      alu_sll = 3'b001,
      alu_sra = 3'b010,
      alu_sub = 3'b011,
      alu_xor = 3'b100,
      alu_srl = 3'b101,
      alu_or  = 3'b110,
      alu_and = 3'b111
   } alu_ops_t;

   typedef enum logic {alu1_rs1, alu1_pc} alumux1_sel_t;

   typedef enum logic [2:0] {
      alu2_i_imm, alu2_u_imm, alu2_b_imm, alu2_s_imm, alu2_j_imm, alu2_rs2
   } alumux2_sel_t;

   typedef enum logic {cmp_rs2, cmp_i_imm} cmpmux_sel_t;

   typedef enum logic [3:0] {
      rf_alu_out, rf_br_en, rf_u_imm, rf_lw, rf_pc_plus4,
      rf_lb, rf_lbu, rf_lh, rf_lhu, rf_muldiv_out
   } regfilemux_sel_t;

   // Jump/branch target base: PC-relative, or rs1-relative for jalr.
   typedef enum logic {tgt_pc_imm, tgt_rs1_imm} targetmux_sel_t;

   typedef enum logic [1:0] {md_none, md_mul, md_div} md_kind_t;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef struct packed {
      logic [6:0]      opcode;
      alu_ops_t        aluop;
      branch_funct3_t  cmpop;
      alumux1_sel_t    alumux1_sel;
      alumux2_sel_t    alumux2_sel;
      cmpmux_sel_t     cmpmux_sel;
      regfilemux_sel_t regfilemux_sel;
      targetmux_sel_t  targetmux_sel;
      logic            load_regfile;
      logic            mem_read;
      logic            mem_write;
      logic            load_pc;
      md_kind_t        md_kind;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [4:0]      rs1_id;
      logic [4:0]      rs2_id;
      logic [4:0]      rd_id;
   } rv32i_control_word;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Bundle between the ID stage/fetch side (master) and the control pipeline
// (slave).
//   id_valid, id_instr : ID-stage instruction and its valid bit
//   flush, mem_stall   : branch kill of ID, global memory freeze
//   stage_ctrl/valid   : registered control word and valid per post-ID stage
//   stall_fe           : hold PC and IF/ID
//   md_active/md_first : mul/div occupying EX, and its start pulse
interface ctrl_pipe_if
   import ctrl_pipe_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 3
) ();

   logic                                   id_valid;
   logic [31:0]                            id_instr;
   logic                                   flush;
   logic                                   mem_stall;
   rv32i_control_word [NUM_STAGES-1:0]     stage_ctrl;
   logic [NUM_STAGES-1:0]                  stage_valid;
   logic                                   stall_fe;
   logic                                   md_active;
   logic                                   md_first;

   modport master (
      output id_valid, id_instr, flush, mem_stall,
      input  stage_ctrl, stage_valid, stall_fe, md_active, md_first
   );

   modport slave (
      input  id_valid, id_instr, flush, mem_stall,
      output stage_ctrl, stage_valid, stall_fe, md_active, md_first
   );

endinterface

// File: rtl/ctrl_pipe_decode.sv
// Pure combinational ID decode of one RV32I(M) instruction.
//   instr    : instruction word
//   ctrl     : decoded control word (unknown opcode -> bubble with load_pc=1)
//   uses_rs1 : instruction reads rs1
//   uses_rs2 : instruction reads rs2
module ctrl_decode
   import ctrl_pipe_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [31:0]       instr,
   output rv32i_control_word ctrl,
   output logic              uses_rs1,
   output logic              uses_rs2
);

   logic [2:0] funct3;
   logic [6:0] funct7;

   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   always_comb begin
      ctrl          = '0;
      ctrl.opcode   = instr[6:0];
      ctrl.funct3   = funct3;
      ctrl.funct7   = funct7;
      ctrl.rs1_id   = instr[19:15];
      ctrl.rs2_id   = instr[24:20];
      ctrl.rd_id    = instr[11:7];
      ctrl.load_pc  = 1'b1;
      uses_rs1      = 1'b0;
      uses_rs2      = 1'b0;

      case (instr[6:0])
         op_lui: begin
            ctrl.load_regfile   = 1'b1;
            ctrl.regfilemux_sel = rf_u_imm;
         end
         op_auipc: begin
            ctrl.alumux1_sel    = alu1_pc;
            ctrl.alumux2_sel    = alu2_u_imm;
            ctrl.load_regfile   = 1'b1;
         end
         op_jal: begin
            ctrl.alumux1_sel    = alu1_pc;
            ctrl.alumux2_sel    = alu2_j_imm;
            ctrl.targetmux_sel  = tgt_pc_imm;
            ctrl.regfilemux_sel = rf_pc_plus4;
            ctrl.load_regfile   = 1'b1;
         end
         op_jalr: begin
            uses_rs1            = 1'b1;
            ctrl.alumux2_sel    = alu2_i_imm;
            ctrl.targetmux_sel  = tgt_rs1_imm;
            ctrl.regfilemux_sel = rf_pc_plus4;
            ctrl.load_regfile   = 1'b1;
         end
         op_br: begin
            uses_rs1            = 1'b1;
            uses_rs2            = 1'b1;
            ctrl.cmpop          = branch_funct3_t'(funct3);
            ctrl.alumux1_sel    = alu1_pc;
            ctrl.alumux2_sel    = alu2_b_imm;
            ctrl.targetmux_sel  = tgt_pc_imm;
         end
         op_load: begin
            uses_rs1            = 1'b1;
            ctrl.alumux2_sel    = alu2_i_imm;
            ctrl.mem_read       = 1'b1;
            ctrl.load_regfile   = 1'b1;
            case (funct3)
               lb:      ctrl.regfilemux_sel = rf_lb;
               lh:      ctrl.regfilemux_sel = rf_lh;
               lbu:     ctrl.regfilemux_sel = rf_lbu;
               lhu:     ctrl.regfilemux_sel = rf_lhu;
               default: ctrl.regfilemux_sel = rf_lw;
            endcase
         end
         op_store: begin
            uses_rs1            = 1'b1;
            uses_rs2            = 1'b1;
            ctrl.alumux2_sel    = alu2_s_imm;
            ctrl.mem_write      = 1'b1;
         end
         op_imm: begin
            uses_rs1            = 1'b1;
            ctrl.alumux2_sel    = alu2_i_imm;
            ctrl.load_regfile   = 1'b1;
            case (funct3)
               slt_f3: begin
                  ctrl.cmpop          = blt;
                  ctrl.cmpmux_sel     = cmp_i_imm;
                  ctrl.regfilemux_sel = rf_br_en;
               end
               sltu_f3: begin
                  ctrl.cmpop          = bltu;
                  ctrl.cmpmux_sel     = cmp_i_imm;
                  ctrl.regfilemux_sel = rf_br_en;
               end
               sr_f3:   ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
               default: ctrl.aluop = alu_ops_t'(funct3);
            endcase
         end
         op_reg: begin
            uses_rs1            = 1'b1;
            uses_rs2            = 1'b1;
            ctrl.load_regfile   = 1'b1;
            if (ENABLE_M && funct7 == FUNCT7_MULDIV) begin
               ctrl.regfilemux_sel = rf_muldiv_out;
               ctrl.md_kind        = funct3[2] ? md_div : md_mul;
            end else begin
               ctrl.alumux2_sel = alu2_rs2;
               case (funct3)
                  slt_f3: begin
                     ctrl.cmpop          = blt;
                     ctrl.regfilemux_sel = rf_br_en;
                  end
                  sltu_f3: begin
                     ctrl.cmpop          = bltu;
                     ctrl.regfilemux_sel = rf_br_en;
                  end
                  add_f3:  ctrl.aluop = funct7[5] ? alu_sub : alu_add;
                  sr_f3:   ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
                  default: ctrl.aluop = alu_ops_t'(funct3);
               endcase
            end
         end
         default: ;  // bubble: no enables, PC still advances
      endcase

      if (ctrl.rd_id == 5'd0) begin
         ctrl.load_regfile = 1'b0;
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: decodes the ID instruction and carries its control word
// through NUM_STAGES post-ID registers (0 = EX, NUM_STAGES-1 = WB), resolving
// memory freeze, multi-cycle mul/div EX hold, load-use stall and flush.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ctrl_pipe_if slave (ID inputs, stage outputs, stall/md status)
// bus must be instantiated with the same NUM_STAGES as this module.
module ctrl_pipe
   import ctrl_pipe_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 3,
   parameter bit          ENABLE_M   = 1'b1,
   parameter int unsigned MUL_LAT    = 1,
   parameter int unsigned DIV_LAT    = 33
) (
   input logic        clk,
   input logic        rst_n,
   ctrl_pipe_if.slave bus
);

   localparam logic [6:0] MUL_CNT = 7'(MUL_LAT);
   localparam logic [6:0] DIV_CNT = 7'(DIV_LAT);

   rv32i_control_word                  id_ctrl;
   logic                               uses_rs1;
   logic                               uses_rs2;

   rv32i_control_word [NUM_STAGES-1:0] ctrl_q, ctrl_d;
   logic [NUM_STAGES-1:0]              valid_q, valid_d;
   logic [6:0]                         cnt_q, cnt_d;
   logic                               md_active_q, md_active_d;
   logic                               md_first_q, md_first_d;

   logic                               load_use;
   logic                               hold_ex;
   logic                               md_enter;
   logic [6:0]                         md_lat;
   logic                               stall_fe;

   ctrl_decode #(
      .ENABLE_M (ENABLE_M)
   ) u_decode (
      .instr    (bus.id_instr),
      .ctrl     (id_ctrl),
      .uses_rs1 (uses_rs1),
      .uses_rs2 (uses_rs2)
   );

   assign load_use = valid_q[0] && ctrl_q[0].mem_read && (ctrl_q[0].rd_id != 5'd0) &&
                     ((uses_rs1 && ctrl_q[0].rd_id == id_ctrl.rs1_id) ||
                      (uses_rs2 && ctrl_q[0].rd_id == id_ctrl.rs2_id));

   // Counter value 1 marks the last EX cycle: stage 0 may advance.
   assign hold_ex  = md_active_q && (cnt_q != 7'd1);
   assign md_enter = bus.id_valid && !bus.flush && (id_ctrl.md_kind != md_none);
   assign md_lat   = (id_ctrl.md_kind == md_div) ? DIV_CNT : MUL_CNT;

   always_comb begin
      ctrl_d      = ctrl_q;
      valid_d     = valid_q;
      cnt_d       = cnt_q;
      md_active_d = md_active_q;
      md_first_d  = md_first_q;
      stall_fe    = 1'b0;

      if (bus.mem_stall) begin
         stall_fe = 1'b1;
      end else if (hold_ex) begin
         // EX keeps the mul/div; a bubble drains behind it.
         stall_fe = 1'b1;
         for (int i = 2; i < NUM_STAGES; i++) begin
            ctrl_d[i]  = ctrl_q[i-1];
            valid_d[i] = valid_q[i-1];
         end
         ctrl_d[1]  = '0;
         valid_d[1] = 1'b0;
         cnt_d      = cnt_q - 7'd1;
         md_first_d = 1'b0;
      end else begin
         for (int i = 1; i < NUM_STAGES; i++) begin
            ctrl_d[i]  = ctrl_q[i-1];
            valid_d[i] = valid_q[i-1];
         end
         if (load_use) begin
            stall_fe    = 1'b1;
            ctrl_d[0]   = '0;
            valid_d[0]  = 1'b0;
            cnt_d       = '0;
            md_active_d = 1'b0;
            md_first_d  = 1'b0;
         end else begin
            ctrl_d[0]   = id_ctrl;
            valid_d[0]  = bus.id_valid && !bus.flush;
            md_first_d  = md_enter;
            cnt_d       = md_enter ? md_lat : 7'd0;
            md_active_d = md_enter && (md_lat > 7'd1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q      <= '0;
         valid_q     <= '0;
         cnt_q       <= '0;
         md_active_q <= 1'b0;
         md_first_q  <= 1'b0;
      end else begin
         ctrl_q      <= ctrl_d;
         valid_q     <= valid_d;
         cnt_q       <= cnt_d;
         md_active_q <= md_active_d;
         md_first_q  <= md_first_d;
      end
   end

   assign bus.stage_ctrl  = ctrl_q;
   assign bus.stage_valid = valid_q;
   assign bus.stall_fe    = stall_fe;
   assign bus.md_active   = md_active_q;
   assign bus.md_first    = md_first_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;
   import ctrl_pipe_pkg::*;

   localparam logic [6:0] OPC_REG   = 7'b0110011;
   localparam logic [6:0] OPC_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   n_stall;
   int   n_bub;
   int   n_first;

   ctrl_pipe_if #(.NUM_STAGES(3)) bus ();

   ctrl_pipe #(
      .NUM_STAGES (3),
      .ENABLE_M   (1'b1),
      .MUL_LAT    (1),
      .DIV_LAT    (33)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Count cycles with stall_fe high, advancing one clock per cycle.
   task automatic run_stall(input int limit);
      n_stall = 0;
      n_bub   = 0;
      n_first = 0;
      while (bus.stall_fe && n_stall < limit) begin
         n_stall++;
         tick();
         if (!bus.stage_valid[1]) n_bub++;
         if (bus.md_first) n_first++;
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      bus.id_valid  = 1'b0;
      bus.id_instr  = 32'h0000_0013;
      bus.flush     = 1'b0;
      bus.mem_stall = 1'b0;
      #12;
      chk("rst_valid", 32'(bus.stage_valid), 32'h0);
      chk("rst_ctrl_zero", 32'(bus.stage_ctrl == '0), 32'h1);
      chk("rst_md", 32'({bus.md_active, bus.md_first, bus.stall_fe}), 32'h0);
      rst_n = 1'b1;
      tick();

      // Load-use: lw x5,0(x1) ; add x6,x5,x2
      bus.id_valid = 1'b1;
      bus.id_instr = enc_i(12'd0, 5'd1, 3'b010, 5'd5, OPC_LOAD);
      tick();
      chk("lw_s0_memread", 32'(bus.stage_ctrl[0].mem_read), 32'h1);
      chk("lw_rfmux", 32'(bus.stage_ctrl[0].regfilemux_sel), 32'(rf_lw));
      bus.id_instr = enc_r(7'd0, 5'd2, 5'd5, 3'b000, 5'd6, OPC_REG);
      #1;
      chk("lu_stall", 32'(bus.stall_fe), 32'h1);
      tick();
      chk("lu_bubble_valid", 32'(bus.stage_valid), 32'b010);
      chk("lu_stall_1cyc", 32'(bus.stall_fe), 32'h0);
      tick();
      chk("lu_add_valid", 32'(bus.stage_valid), 32'b101);
      chk("lu_add_rs1", 32'(bus.stage_ctrl[0].rs1_id), 32'd5);
      chk("lu_lw_s2", 32'(bus.stage_ctrl[2].mem_read), 32'h1);

      // rs2 dependence stalls, no-source instruction does not
      bus.id_instr = enc_i(12'd0, 5'd1, 3'b010, 5'd5, OPC_LOAD);
      tick();
      bus.id_instr = enc_r(7'd0, 5'd5, 5'd2, 3'b010, 5'd4, OPC_STORE);
      #1;
      chk("lu_store_rs2", 32'(bus.stall_fe), 32'h1);
      bus.id_instr = {20'h12345, 5'd5, OPC_LUI};
      #1;
      chk("lu_lui_nostall", 32'(bus.stall_fe), 32'h0);
      tick();

      // lw x0 ; add x6,x0,x2 -> no stall, no regfile write for x0
      bus.id_instr = enc_i(12'd0, 5'd1, 3'b010, 5'd0, OPC_LOAD);
      tick();
      chk("x0_load_regfile", 32'(bus.stage_ctrl[0].load_regfile), 32'h0);
      bus.id_instr = enc_r(7'd0, 5'd2, 5'd0, 3'b000, 5'd6, OPC_REG);
      #1;
      chk("x0_nostall", 32'(bus.stall_fe), 32'h0);
      tick();
      chk("x0_add_lr", 32'({bus.stage_valid[0], bus.stage_ctrl[0].load_regfile}), 32'b11);

      // Unknown opcode -> bubble with load_pc
      bus.id_instr = 32'hffff_ffff;
      tick();
      chk("unk_bubble", 32'({bus.stage_ctrl[0].load_regfile, bus.stage_ctrl[0].mem_read,
                            bus.stage_ctrl[0].mem_write, bus.stage_ctrl[0].load_pc}), 32'b0001);

      // div x3,x4,x5 with DIV_LAT=33
      bus.id_instr = enc_r(7'b0000001, 5'd5, 5'd4, 3'b100, 5'd3, OPC_REG);
      tick();
      chk("div_first", 32'({bus.md_first, bus.md_active}), 32'b11);
      chk("div_kind", 32'(bus.stage_ctrl[0].md_kind), 32'(md_div));
      chk("div_rfmux", 32'(bus.stage_ctrl[0].regfilemux_sel), 32'(rf_muldiv_out));
      bus.id_instr = enc_i(12'd1, 5'd0, 3'b000, 5'd7, OPC_IMM);
      run_stall(40);
      chk("div_stall_cycles", 32'(n_stall), 32'd32);
      chk("div_s1_bubbles", 32'(n_bub), 32'd32);
      chk("div_first_once", 32'(n_first), 32'd0);
      tick();
      chk("div_in_s1", 32'(bus.stage_ctrl[1].md_kind), 32'(md_div));
      chk("div_next_nogap", 32'({bus.stage_valid[1:0], bus.stage_ctrl[0].rd_id}), 32'h67);
      chk("div_active_done", 32'(bus.md_active), 32'h0);

      // mul with MUL_LAT=1 then addi
      bus.id_instr = enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd8, OPC_REG);
      tick();
      chk("mul_first", 32'({bus.md_first, bus.md_active}), 32'b10);
      chk("mul_kind", 32'(bus.stage_ctrl[0].md_kind), 32'(md_mul));
      bus.id_instr = enc_i(12'd1, 5'd0, 3'b000, 5'd7, OPC_IMM);
      #1;
      chk("mul_nostall", 32'(bus.stall_fe), 32'h0);
      tick();
      chk("mul_after", 32'({bus.md_first, bus.md_active, bus.stage_valid[0]}), 32'b001);

      // Flush with beq in EX and addi in ID
      bus.id_instr = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd0, OPC_BR);
      tick();
      bus.id_instr = enc_i(12'd1, 5'd0, 3'b000, 5'd9, OPC_IMM);
      bus.flush    = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("flush_s0_valid", 32'(bus.stage_valid[1:0]), 32'b10);
      chk("flush_beq_s1", 32'(bus.stage_ctrl[1].opcode), 32'(OPC_BR));

      // Flush during a div hold leaves the div alone
      bus.id_instr = enc_r(7'b0000001, 5'd5, 5'd4, 3'b100, 5'd3, OPC_REG);
      tick();
      bus.id_instr = enc_i(12'd1, 5'd0, 3'b000, 5'd7, OPC_IMM);
      bus.flush    = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("fdiv_kept", 32'({bus.stage_valid[0], bus.stall_fe}), 32'b11);
      run_stall(40);
      chk("fdiv_remaining", 32'(n_stall), 32'd31);
      tick();
      chk("fdiv_in_s1", 32'(bus.stage_ctrl[1].md_kind), 32'(md_div));

      // mem_stall for 4 cycles while the div counter is 10
      bus.id_instr = enc_r(7'b0000001, 5'd5, 5'd4, 3'b100, 5'd3, OPC_REG);
      tick();
      bus.id_instr = enc_i(12'd1, 5'd0, 3'b000, 5'd7, OPC_IMM);
      repeat (23) tick();
      bus.mem_stall = 1'b1;
      #1;
      chk("ms_stall", 32'(bus.stall_fe), 32'h1);
      repeat (4) tick();
      chk("ms_frozen_valid", 32'(bus.stage_valid), 32'b001);
      chk("ms_frozen_md", 32'({bus.md_active, bus.md_first}), 32'b10);
      chk("ms_frozen_kind", 32'(bus.stage_ctrl[0].md_kind), 32'(md_div));
      bus.mem_stall = 1'b0;
      run_stall(40);
      chk("ms_resume_cnt", 32'(n_stall), 32'd9);
      tick();

      // Asynchronous reset in the middle of a div hold
      bus.id_instr = enc_r(7'b0000001, 5'd5, 5'd4, 3'b100, 5'd3, OPC_REG);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.stage_valid), 32'h0);
      chk("arst_md", 32'({bus.md_active, bus.md_first, bus.stall_fe}), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
